// File: rtl/hqm_sbecollect_pkg.sv
// Shared types and constants for the sideband target message collector.
// The collector's optional per-flit parity check is enabled with HQM_SBE_COLLECT_PARCHK_EN.
package hqm_sbecollect_pkg;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_e;

  localparam int DEST_LSB = 0;
  localparam int SRC_LSB  = 8;
  localparam int OPC_LSB  = 16;
  localparam int TAG_LSB  = 24;
  localparam int EH_BIT   = 31;

  // Header dword as it arrives on the wire: bits [30:27] are not decoded
  typedef struct packed {
    logic       eh;
    logic [3:0] rsvd;
    logic [2:0] tag;
    logic [7:0] opcode;
    logic [7:0] src;
    logic [7:0] dest;
  } hdr_t;

  localparam int ERR_OVF = 2;
  localparam int ERR_MAL = 1;
  localparam int ERR_PAR = 0;

  // Flit payload width in bytes for a given payload MSB
  function automatic int flit_bytes(input int pldbit);
    return (pldbit + 1) / 8;
  endfunction

endpackage

// File: rtl/hqm_sbecollect_dwpack.sv
// Byte-lane packer: gathers 8/16/32-bit flits into little-endian 32-bit dwords.
// A dword completes when its last lane is written or when eom closes it early;
// an early close leaves the unwritten upper lanes at zero and raises o_partial.
module hqm_sbecollect_dwpack #(
  parameter int INTERNALPLDBIT = 31
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    i_put,
  input  logic                    i_eom,
  input  logic                    i_clear,
  input  logic [INTERNALPLDBIT:0] i_payload,
  output logic                    o_dw_done,
  output logic [31:0]             o_dw_data,
  output logic                    o_partial
);
  import hqm_sbecollect_pkg::*;

  localparam int         FLIT_BITS = 8 * flit_bytes(INTERNALPLDBIT);
  localparam int         LANES     = 32 / FLIT_BITS;
  localparam logic [1:0] LAST_LANE = 2'(LANES - 1);

  logic [1:0]  r_bcnt;
  logic [31:0] r_asm;
  logic [31:0] w_flit_sh;
  logic        w_last;

  assign w_last    = (r_bcnt == LAST_LANE);
  assign w_flit_sh = 32'(i_payload) << (32'(r_bcnt) * FLIT_BITS);
  assign o_dw_data = r_asm | w_flit_sh;
  assign o_dw_done = i_put & (w_last | i_eom);
  assign o_partial = i_put & i_eom & ~w_last;

  // Lane counter and assembly register; both restart after every completed dword
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_bcnt <= '0;
      r_asm  <= '0;
    end else if (i_clear || o_dw_done) begin
      r_bcnt <= '0;
      r_asm  <= '0;
    end else if (i_put) begin
      r_bcnt <= r_bcnt + 2'd1;
      r_asm  <= o_dw_data;
    end
  end

endmodule

// File: rtl/hqm_sbetgt_msgcollect.sv
// Message collector downstream of the target repeater's IP-side flit port.
// Packs flits into dwords, decodes dword 0 as the header, buffers up to MAXDW
// data dwords and holds the whole message on a valid/ready port.
// Optional parity checking: define HQM_SBE_COLLECT_PARCHK_EN.
//
// state   | meaning
// INIT    | one cycle after reset, not yet free
// COLLECT | tmsg_free=1, accepting flits until eom
// HOLD    | message presented, waiting for msg_ready
module hqm_sbetgt_msgcollect #(
  parameter int INTERNALPLDBIT = 31,
  parameter int MAXDW          = 4,
  parameter int DWCW           = 4
) (
  input  logic                    agent_clk,
  input  logic                    agent_rst_b,
  input  logic                    tmsg_put,
  input  logic                    tmsg_eom,
  input  logic                    tmsg_parity,
  input  logic [INTERNALPLDBIT:0] tmsg_payload,
  output logic                    tmsg_free,
  output logic                    msg_valid,
  input  logic                    msg_ready,
  output logic [7:0]              msg_dest,
  output logic [7:0]              msg_src,
  output logic [7:0]              msg_opcode,
  output logic [2:0]              msg_tag,
  output logic                    msg_eh,
  output logic [32*MAXDW-1:0]     msg_data,
  output logic [DWCW-1:0]         msg_dwcount,
  output logic [2:0]              msg_err
);
  import hqm_sbecollect_pkg::*;

  localparam logic [DWCW-1:0] LP_MAXDW = DWCW'(MAXDW);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic                    r_free;
  logic                    r_valid;
  logic                    w_free_nxt;
  logic                    w_valid_nxt;
  hdr_t                    r_hdr;
  logic                    r_hdr_done;
  logic [MAXDW-1:0][31:0]  r_data;
  logic [DWCW-1:0]         r_dwcount;
  logic [2:0]              r_err;
  logic                    w_acc;
  logic                    w_eom_acc;
  logic                    w_hs;
  logic                    w_dw_done;
  logic [31:0]             w_dw_data;
  logic                    w_partial;
  logic                    w_parerr;
  logic [3:0]              w_unused_rsvd;

  // Puts offered while not free are dropped here
  assign w_acc     = tmsg_put & r_free;
  assign w_eom_acc = w_acc & tmsg_eom;
  assign w_hs      = r_valid & msg_ready;

`ifdef HQM_SBE_COLLECT_PARCHK_EN
  assign w_parerr = w_acc & (^{tmsg_eom, tmsg_payload, tmsg_parity});
`else
  logic w_unused_parity;
  assign w_unused_parity = tmsg_parity;
  assign w_parerr        = 1'b0;
`endif

  hqm_sbecollect_dwpack #(
    .INTERNALPLDBIT(INTERNALPLDBIT)
  ) u_dwpack (
    .clk       (agent_clk),
    .rst_b     (agent_rst_b),
    .i_put     (w_acc),
    .i_eom     (tmsg_eom),
    .i_clear   (w_hs),
    .i_payload (tmsg_payload),
    .o_dw_done (w_dw_done),
    .o_dw_data (w_dw_data),
    .o_partial (w_partial)
  );

  // State register
  always_ff @(posedge agent_clk or negedge agent_rst_b) begin
    if (!agent_rst_b) r_state <= INIT;
    else              r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      INIT:    w_state_nxt = COLLECT;
      COLLECT: if (w_eom_acc) w_state_nxt = HOLD;
      HOLD:    if (w_hs)      w_state_nxt = COLLECT;
      default: w_state_nxt = INIT;
    endcase
  end

  // Next values of the registered handshake outputs
  always_comb begin
    w_free_nxt  = r_free;
    w_valid_nxt = r_valid;
    case (r_state)
      INIT: w_free_nxt = 1'b1;
      COLLECT: if (w_eom_acc) begin
        w_free_nxt  = 1'b0;
        w_valid_nxt = 1'b1;
      end
      HOLD: if (w_hs) begin
        w_free_nxt  = 1'b1;
        w_valid_nxt = 1'b0;
      end
      default: begin
        w_free_nxt  = 1'b0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // Handshake output registers
  always_ff @(posedge agent_clk or negedge agent_rst_b) begin
    if (!agent_rst_b) begin
      r_free  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_free  <= w_free_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // Dword routing into header/data buffers and sticky error capture
  always_ff @(posedge agent_clk or negedge agent_rst_b) begin
    if (!agent_rst_b) begin
      r_hdr      <= '0;
      r_hdr_done <= 1'b0;
      r_data     <= '0;
      r_dwcount  <= '0;
      r_err      <= '0;
    end else if (w_hs) begin
      r_hdr      <= '0;
      r_hdr_done <= 1'b0;
      r_data     <= '0;
      r_dwcount  <= '0;
      r_err      <= '0;
    end else if (w_acc) begin
      if (w_dw_done) begin
        if (!r_hdr_done) begin
          r_hdr      <= hdr_t'(w_dw_data);
          r_hdr_done <= 1'b1;
        end else if (r_dwcount < LP_MAXDW) begin
          for (int k = 0; k < MAXDW; k++) begin
            if (r_dwcount == DWCW'(k)) r_data[k] <= w_dw_data;
          end
          r_dwcount <= r_dwcount + 1'b1;
        end else begin
          r_err[ERR_OVF] <= 1'b1;
        end
      end
      if (w_partial) r_err[ERR_MAL] <= 1'b1;
      if (w_parerr)  r_err[ERR_PAR] <= 1'b1;
    end
  end

  assign w_unused_rsvd = r_hdr.rsvd;

  assign tmsg_free   = r_free;
  assign msg_valid   = r_valid;
  assign msg_dest    = r_hdr.dest;
  assign msg_src     = r_hdr.src;
  assign msg_opcode  = r_hdr.opcode;
  assign msg_tag     = r_hdr.tag;
  assign msg_eh      = r_hdr.eh;
  assign msg_data    = r_data;
  assign msg_dwcount = r_dwcount;
  assign msg_err     = r_err;

`ifdef SIMONLY
  // A put while not free is a protocol violation by the repeater
  a_put_needs_free: assert property (@(posedge agent_clk) disable iff (!agent_rst_b)
    tmsg_put |-> r_free);
`endif

endmodule

// File: tb/tb_hqm_sbetgt_msgcollect.sv
// Bench for hqm_sbetgt_msgcollect: three instances (32/16/8-bit flits) sharing
// one stimulus bus; only the selected instance sees put/ready. Expected results
// come from a byte-stream model of the message.
`timescale 1ns/1ps
module tb_hqm_sbetgt_msgcollect;
  localparam int MAXDW = 4;
  localparam int DWCW  = 4;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        put, eom, par, ready;
  logic [31:0] pld;
  int          sel;

  logic         put_v[3], rdy_v[3];
  logic         free_v[3], valid_v[3], eh_v[3];
  logic [7:0]   dest_v[3], src_v[3], opc_v[3];
  logic [2:0]   tag_v[3], err_v[3];
  logic [127:0] data_v[3];
  logic [3:0]   cnt_v[3];

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0]  exp_h;
  logic [127:0] exp_d;
  logic [3:0]   exp_c;
  logic [2:0]   exp_e;

  logic [31:0] fl[$];
  bit          fq[$];

  always #5 clk = ~clk;

  assign put_v[0] = put & (sel == 0);
  assign put_v[1] = put & (sel == 1);
  assign put_v[2] = put & (sel == 2);
  assign rdy_v[0] = ready & (sel == 0);
  assign rdy_v[1] = ready & (sel == 1);
  assign rdy_v[2] = ready & (sel == 2);

  hqm_sbetgt_msgcollect #(.INTERNALPLDBIT(31), .MAXDW(MAXDW), .DWCW(DWCW)) u_dut32 (
    .agent_clk(clk), .agent_rst_b(rst_b), .tmsg_put(put_v[0]), .tmsg_eom(eom),
    .tmsg_parity(par), .tmsg_payload(pld), .tmsg_free(free_v[0]), .msg_valid(valid_v[0]),
    .msg_ready(rdy_v[0]), .msg_dest(dest_v[0]), .msg_src(src_v[0]), .msg_opcode(opc_v[0]),
    .msg_tag(tag_v[0]), .msg_eh(eh_v[0]), .msg_data(data_v[0]), .msg_dwcount(cnt_v[0]),
    .msg_err(err_v[0]));

  hqm_sbetgt_msgcollect #(.INTERNALPLDBIT(15), .MAXDW(MAXDW), .DWCW(DWCW)) u_dut16 (
    .agent_clk(clk), .agent_rst_b(rst_b), .tmsg_put(put_v[1]), .tmsg_eom(eom),
    .tmsg_parity(par), .tmsg_payload(pld[15:0]), .tmsg_free(free_v[1]), .msg_valid(valid_v[1]),
    .msg_ready(rdy_v[1]), .msg_dest(dest_v[1]), .msg_src(src_v[1]), .msg_opcode(opc_v[1]),
    .msg_tag(tag_v[1]), .msg_eh(eh_v[1]), .msg_data(data_v[1]), .msg_dwcount(cnt_v[1]),
    .msg_err(err_v[1]));

  hqm_sbetgt_msgcollect #(.INTERNALPLDBIT(7), .MAXDW(MAXDW), .DWCW(DWCW)) u_dut8 (
    .agent_clk(clk), .agent_rst_b(rst_b), .tmsg_put(put_v[2]), .tmsg_eom(eom),
    .tmsg_parity(par), .tmsg_payload(pld[7:0]), .tmsg_free(free_v[2]), .msg_valid(valid_v[2]),
    .msg_ready(rdy_v[2]), .msg_dest(dest_v[2]), .msg_src(src_v[2]), .msg_opcode(opc_v[2]),
    .msg_tag(tag_v[2]), .msg_eh(eh_v[2]), .msg_data(data_v[2]), .msg_dwcount(cnt_v[2]),
    .msg_err(err_v[2]));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int fb_of(input int s);
    return (s == 0) ? 4 : (s == 1) ? 2 : 1;
  endfunction

  function automatic logic [31:0] mask_of(input int fb);
    return (fb == 4) ? 32'hFFFF_FFFF : (fb == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
  endfunction

  // Reference: flatten flits to a byte stream, cut into dwords, zero-pad the tail
  task automatic model(input int fb, input logic [31:0] f[$], input bit anyflip);
    logic [7:0]  b[$];
    logic [31:0] dw;
    int          ndw;
    bit          mal;
    b = {};
    foreach (f[i]) for (int k = 0; k < fb; k++) b.push_back(f[i][8*k +: 8]);
    mal = (b.size() % 4) != 0;
    while (b.size() % 4 != 0) b.push_back(8'h00);
    ndw = b.size() / 4;
    exp_h = '0;
    exp_d = '0;
    for (int d = 0; d < ndw; d++) begin
      dw = {b[4*d+3], b[4*d+2], b[4*d+1], b[4*d]};
      if (d == 0) exp_h = dw;
      else if (d <= MAXDW) exp_d[32*(d-1) +: 32] = dw;
    end
    exp_c = 4'((ndw - 1 > MAXDW) ? MAXDW : ndw - 1);
`ifdef HQM_SBE_COLLECT_PARCHK_EN
    exp_e = {ndw - 1 > MAXDW, mal, anyflip};
`else
    exp_e = {ndw - 1 > MAXDW, mal, 1'b0};
`endif
  endtask

  task automatic check_msg(input string p, input int s);
    check({p, "_dest"},  dest_v[s], exp_h[7:0]);
    check({p, "_src"},   src_v[s],  exp_h[15:8]);
    check({p, "_opc"},   opc_v[s],  exp_h[23:16]);
    check({p, "_tag"},   tag_v[s],  exp_h[26:24]);
    check({p, "_eh"},    eh_v[s],   exp_h[31]);
    check({p, "_data"},  data_v[s], exp_d);
    check({p, "_count"}, cnt_v[s],  exp_c);
    check({p, "_err"},   err_v[s],  exp_e);
  endtask

  task automatic noflip(input int n);
    fq = {};
    for (int i = 0; i < n; i++) fq.push_back(1'b0);
  endtask

  task automatic send_msg(input string p, input int s, input int gapmax);
    int fb, w;
    bit anyf;
    fb = fb_of(s);
    sel = s;
    anyf = 1'b0;
    foreach (fq[i]) anyf |= fq[i];
    model(fb, fl, anyf);
    w = 0;
    while (free_v[s] !== 1'b1 && w < 20) begin tick(); w++; end
    check({p, "_free_before"}, free_v[s], 1'b1);
    foreach (fl[i]) begin
      repeat ($urandom_range(0, gapmax)) tick();
      put = 1'b1;
      eom = (i == fl.size() - 1);
      pld = fl[i] & mask_of(fb);
      par = (^{eom, pld}) ^ fq[i];
      tick();
      put = 1'b0;
      eom = 1'b0;
    end
    check({p, "_valid"}, valid_v[s], 1'b1);
    check({p, "_free_after_eom"}, free_v[s], 1'b0);
    check_msg(p, s);
  endtask

  // Hold the message, throwing illegal puts at it, then handshake it away
  task automatic release_msg(input string p, input int s, input int holdcyc);
    for (int c = 0; c < holdcyc; c++) begin
      put = 1'($urandom_range(0, 1));
      eom = 1'($urandom_range(0, 1));
      pld = $urandom;
      tick();
      check({p, "_hold_valid"}, valid_v[s], 1'b1);
      check({p, "_hold_free"}, free_v[s], 1'b0);
      check({p, "_hold_fields"},
            {dest_v[s], src_v[s], opc_v[s], tag_v[s], eh_v[s], cnt_v[s], err_v[s]},
            {exp_h[7:0], exp_h[15:8], exp_h[23:16], exp_h[26:24], exp_h[31], exp_c, exp_e});
      check({p, "_hold_data"}, data_v[s], exp_d);
    end
    put = 1'b0;
    eom = 1'b0;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check({p, "_valid_drop"}, valid_v[s], 1'b0);
    check({p, "_free_back"}, free_v[s], 1'b1);
    check({p, "_count_clr"}, cnt_v[s], 4'd0);
    check({p, "_err_clr"}, err_v[s], 3'd0);
  endtask

  initial begin
    int s, nf;
    rst_b = 1'b0;
    put = 1'b0; eom = 1'b0; par = 1'b0; ready = 1'b0; pld = '0; sel = 0;
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      check("rst_free",  free_v[k], 1'b0);
      check("rst_valid", valid_v[k], 1'b0);
      check("rst_fields", {dest_v[k], src_v[k], opc_v[k], tag_v[k], eh_v[k], cnt_v[k], err_v[k]}, '0);
      check("rst_data",  data_v[k], '0);
    end
    rst_b = 1'b1;
    check("init_free_c1", free_v[0], 1'b0);
    tick();
    check("init_free_c2", free_v[0], 1'b1);

    fl = {32'h5A21_0A0B, 32'hDEAD_BEEF}; noflip(2);
    send_msg("d32", 0, 0);
    check("d32_k_dest", dest_v[0], 8'h0B);
    check("d32_k_tag",  tag_v[0],  3'd2);
    check("d32_k_data0", data_v[0][31:0], 32'hDEAD_BEEF);
    check("d32_k_count", cnt_v[0], 4'd1);
    release_msg("d32", 0, 0);

    fl = {32'h8000_1234}; noflip(1);
    send_msg("single", 0, 0);
    check("single_k_count", cnt_v[0], 4'd0);
    release_msg("single", 0, 2);

    fl = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08}; noflip(8);
    send_msg("d8", 2, 1);
    check("d8_k_data0", data_v[2][31:0], 32'h0807_0605);
    check("d8_k_err", err_v[2], 3'd0);
    release_msg("d8", 2, 0);

    fl = {16'h1111, 16'h2222, 16'h3333}; noflip(3);
    send_msg("d16", 1, 0);
    check("d16_k_data0", data_v[1][31:0], 32'h0000_3333);
    check("d16_k_mal", err_v[1][1], 1'b1);
    release_msg("d16", 1, 0);

    fl = {32'hA0A0_0001, 32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66}; noflip(7);
    send_msg("ovf", 0, 0);
    check("ovf_k_count", cnt_v[0], 4'd4);
    check("ovf_k_flag", err_v[0][2], 1'b1);
    release_msg("ovf", 0, 10);

    fl = {16'hABCD, 16'h1234, 16'h5678, 16'h9ABC}; fq = {1'b0, 1'b1, 1'b0, 1'b0};
    send_msg("par", 1, 0);
    check("par_k_data0", data_v[1][31:0], 32'h9ABC_5678);
    release_msg("par", 1, 0);

    sel = 0;
    put = 1'b1; pld = 32'h0102_0304; par = ^pld; tick();
    pld = 32'hCAFE_F00D; par = ^pld; tick();
    put = 1'b0;
    rst_b = 1'b0;
    #1;
    check("midrst_free",  free_v[0], 1'b0);
    check("midrst_valid", valid_v[0], 1'b0);
    check("midrst_fields", {dest_v[0], src_v[0], opc_v[0], tag_v[0], eh_v[0], cnt_v[0], err_v[0]}, '0);
    check("midrst_data",  data_v[0], '0);
    tick();
    rst_b = 1'b1;
    tick();
    fl = {32'h0000_7788, 32'h1}; noflip(2);
    send_msg("postrst", 0, 0);
    release_msg("postrst", 0, 0);

    for (int m = 0; m < 40; m++) begin
      s  = $urandom_range(0, 2);
      nf = $urandom_range(1, 28 / fb_of(s));
      fl = {}; fq = {};
      for (int i = 0; i < nf; i++) begin
        fl.push_back($urandom & mask_of(fb_of(s)));
        fq.push_back($urandom_range(0, 7) == 0);
      end
      send_msg("rnd", s, 2);
      release_msg("rnd", s, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hqm_sbetgt_msgcollect.md
Name: hqm_sbetgt_msgcollect

Overview:
- Consumer stage directly downstream of the target repeater's IP-side flit interface, one instance per channel (posted or non-posted).
- Accepts put/eom/payload/parity flits and packs them (8/16/32-bit flits) into 32-bit dwords.
- Decodes the first dword as the message header and buffers up to MAXDW data dwords.
- Presents the whole message on a valid/ready interface to agent logic, with free back-pressure toward the repeater.

Parameters:
- INTERNALPLDBIT, 31, flit payload MSB; legal values 7, 15, 31.
- MAXDW, 4, data dwords stored after the header; legal range 1..8.
- DWCW, 4, width of the dword count output; must satisfy 2**DWCW > MAXDW.

Ports:
- agent_clk  in  1  clock.
- agent_rst_b  in  1  asynchronous active-low reset.
- tmsg_put  in  1  flit transfer strobe; only legal while tmsg_free=1.
- tmsg_eom  in  1  last flit of the message; qualified by tmsg_put.
- tmsg_parity  in  1  even parity over {tmsg_eom, tmsg_payload}.
- tmsg_payload  in  INTERNALPLDBIT+1  flit data, little-endian byte order.
- tmsg_free  out  1  registered; collector can take a flit this cycle.
- msg_valid  out  1  assembled message available.
- msg_ready  in  1  consumer accepts the message.
- msg_dest  out  8  header[7:0].
- msg_src  out  8  header[15:8].
- msg_opcode  out  8  header[23:16].
- msg_tag  out  3  header[26:24].
- msg_eh  out  1  header[31].
- msg_data  out  32*MAXDW  data dwords; dword k sits at bits [32k+31:32k]; unwritten dwords read 0.
- msg_dwcount  out  DWCW  number of data dwords stored (0..MAXDW).
- msg_err  out  3  {overflow, malformed, parerr}; sticky per message.

Behaviour:
- Reset: state=INIT, tmsg_free=0, msg_valid=0, all header/data/count/err registers 0, byte counter 0.
- INIT: always moves to COLLECT on the next clock. tmsg_free=1 from the second cycle after reset release.
- COLLECT (tmsg_free=1): each tmsg_put writes the flit into the dword assembly register at byte lane bcnt*(flit bytes).
  - For INTERNALPLDBIT=31, every flit completes a dword.
  - Otherwise bcnt wraps after 4/(flit bytes) flits.
- Dword routing on completion:
  - Dword 0 loads the header fields.
  - Dwords 1..MAXDW load msg_data[dw-1] and increment msg_dwcount.
  - Dwords beyond MAXDW are discarded and set overflow. msg_dwcount saturates at MAXDW.
- put & eom:
  - If bcnt is not at the final lane, set malformed. The partial dword is zero-padded and stored as above.
  - If eom arrives before the header is complete, the header takes the partial value and malformed is set.
  - On that same edge: tmsg_free<=0, msg_valid<=1, state<=HOLD. The cycle after eom therefore presents no free, so no further put can be legal.
- HOLD: outputs stay stable while msg_valid=1 && !msg_ready.
  - On msg_valid & msg_ready: msg_valid<=0; dwcount, err, bcnt, data and header cleared; tmsg_free<=1; state<=COLLECT.
  - Minimum gap between eom and the next accepted flit is 2 cycles.
- A put while tmsg_free=0 is a protocol violation. It is ignored (no state change), and the SIMONLY assertion fires.
- Parity: per-flit check computed as ^{tmsg_eom, tmsg_payload, tmsg_parity}; a value of 1 sets parerr. The flit is still stored.
- Single-flit message (put&eom on the first 32-bit flit): header only, msg_dwcount=0.
- Reset asserted mid-message or in HOLD: everything returns to reset values asynchronously and any partial message is lost.

Optional Feature:
- Macro: HQM_SBE_COLLECT_PARCHK_EN.
- Defined: parity is checked per flit as above and msg_err[0] reports parerr.
- Undefined: no parity logic is built, tmsg_parity is unused, and msg_err[0] is tied to 0.

Decomposition:
- Package hqm_sbecollect_pkg holds:
  - the state enum {INIT, COLLECT, HOLD};
  - header field bit offsets (DEST_LSB=0, SRC_LSB=8, OPC_LSB=16, TAG_LSB=24, EH_BIT=31);
  - a packed header struct;
  - msg_err bit indices.
- One sub-module: hqm_sbecollect_dwpack. It holds the byte-lane counter and dword assembly register, and outputs dw_done, dw_data and partial (eom off-lane).

Test Plan:
- INTERNALPLDBIT=31: puts 0x5A21_0A0B then 0xDEADBEEF with eom, msg_ready=1 -> msg_valid=1 the cycle after eom with dest=0x0B, src=0x0A, opcode=0x21, tag=2, eh=0, data[0]=0xDEADBEEF, dwcount=1, err=0. Then tmsg_free=1 again 1 cycle after the handshake.
- INTERNALPLDBIT=7: 8 byte flits 01..08, eom on 08 -> header=0x04030201, data[0]=0x08070605, dwcount=1, no malformed.
- INTERNALPLDBIT=15: 3 flits, eom on the 3rd -> data[0]=0x0000_<flit3>, malformed=1.
- MAXDW=4 with 6 data dwords -> dwcount=4, data holds dwords 1..4, overflow=1.
- Hold msg_ready=0 for 10 cycles -> tmsg_free=0 and outputs stable throughout; ready pulse -> msg_valid drops and free returns next cycle.
- Flipped parity on flit 2 with macro defined -> parerr=1 and data still stored. Macro undefined -> err=0. Assert reset mid-message -> all outputs back to reset values.
